// File: rtl/clint_mtimer_if.sv
// Register-bus bundle for clint_mtimer: single-cycle request, response one cycle later.
// gnt mirrors req, so the master never stalls.
interface clint_mtimer_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic                    req;
  logic                    we;
  logic [15:0]             addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/clint_mtimer.sv
// Machine timer / IPI block: 64-bit mtime with prescaler, per-hart mtimecmp and msip; response 1 cycle after grant, gnt=req (no backpressure).
// Optional feature CLINT_MTIMER_PRESCALER_EN makes the prescaler writable; otherwise it is fixed at 1 (divide-by-two).
module clint_mtimer #(
  parameter int unsigned NR_HARTS       = 1,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned PRESCALE_RESET = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  input  logic                halt_i,
  clint_mtimer_if.slave       bus,
  output logic [63:0]         mtime_o,
  output logic [NR_HARTS-1:0] timer_irq_o,
  output logic [NR_HARTS-1:0] ipi_o
);

`ifdef CLINT_MTIMER_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  localparam logic [31:0] PRESC_INIT = PRESC_EN ? 32'(PRESCALE_RESET) : 32'd1;
  localparam logic [12:0] NH13       = 13'(NR_HARTS);
  localparam logic [12:0] CMP_BASE   = 13'h0800;
  localparam logic [12:0] PRESC_WA   = 13'h17FE;
  localparam logic [12:0] MTIME_WA   = 13'h17FF;

  // Decode and datapath helpers
  logic [12:0]           wa;
  logic [12:0]           cmp_idx;
  logic [11:0]           msip_idx;
  logic                  lane_ok;
  logic                  msip_hit;
  logic                  cmp_hit;
  logic                  presc_hit;
  logic                  mtime_hit;
  logic                  hit;
  logic                  wen;
  logic                  ren;
  logic [63:0]           wdata64;
  logic [63:0]           wmask64;
  logic [7:0]            wmask8;
  logic [63:0]           rd64;
  logic [DATA_WIDTH-1:0] rd_lane;
  logic                  tick;
  logic                  unused_addr;

  // State
  logic [63:0]           mtime_q, mtime_d;
  logic [31:0]           pcnt_q, pcnt_d;
  logic [31:0]           presc_q, presc_d;
  logic [63:0]           mtimecmp_q [NR_HARTS];
  logic [63:0]           mtimecmp_d [NR_HARTS];
  logic [NR_HARTS-1:0]   msip_q, msip_d;
  logic [NR_HARTS-1:0]   tirq_q, tirq_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Every register is viewed as a 64-bit word; a 32-bit bus picks one half with addr[2].
  generate
    if (DATA_WIDTH == 32) begin : g_dw32
      assign wdata64  = {bus.wdata, bus.wdata};
      assign wmask8   = bus.addr[2] ? {bus.be, 4'b0000} : {4'b0000, bus.be};
      assign lane_ok  = 1'b1;
      assign msip_idx = bus.addr[13:2];
      assign rd_lane  = bus.addr[2] ? rd64[63:32] : rd64[31:0];
    end else begin : g_dw64
      assign wdata64  = bus.wdata;
      assign wmask8   = bus.be;
      assign lane_ok  = ~bus.addr[2];
      assign msip_idx = {bus.addr[13:3], 1'b0};
      assign rd_lane  = rd64;
    end
  endgenerate

  assign unused_addr = ^bus.addr[1:0];

  assign wa        = bus.addr[15:3];
  assign cmp_idx   = wa - CMP_BASE;
  assign msip_hit  = lane_ok && (bus.addr[15:14] == 2'b00) && ({1'b0, msip_idx} < NH13);
  assign cmp_hit   = lane_ok && (wa >= CMP_BASE) && (wa < CMP_BASE + NH13);
  assign presc_hit = lane_ok && (wa == PRESC_WA);
  assign mtime_hit = lane_ok && (wa == MTIME_WA);
  assign hit       = msip_hit || cmp_hit || presc_hit || mtime_hit;
  assign wen       = bus.req && bus.we && hit;
  assign ren       = bus.req && !bus.we && hit;

  always_comb begin
    wmask64 = '0;
    for (int b = 0; b < 8; b++) begin
      wmask64[8*b +: 8] = {8{wmask8[b]}};
    end
  end

  // An msip word holds hart 2w in bit 0 and hart 2w+1 in bit 32.
  always_comb begin
    rd64 = '0;
    if (msip_hit) begin
      for (int h = 0; h < NR_HARTS; h++) begin
        if (bus.addr[13:3] == 11'(h / 2)) begin
          if (h % 2 == 0) rd64[0] = msip_q[h];
          else            rd64[32] = msip_q[h];
        end
      end
    end
    if (cmp_hit) begin
      for (int h = 0; h < NR_HARTS; h++) begin
        if (cmp_idx == 13'(h)) rd64 = mtimecmp_q[h];
      end
    end
    if (presc_hit) rd64 = {32'b0, presc_q};
    if (mtime_hit) rd64 = mtime_q;
  end

  always_comb begin
    tick       = 1'b0;
    pcnt_d     = pcnt_q;
    presc_d    = presc_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    tirq_d     = '0;

    if (!halt_i) begin
      if (testmode_i || (pcnt_q == presc_q)) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 32'd1;
      end
    end
    if (tick) mtime_d = mtime_q + 64'd1;

    // A software write to mtime overrides any tick of the same cycle.
    if (wen && mtime_hit) begin
      mtime_d = (mtime_q & ~wmask64) | (wdata64 & wmask64);
      pcnt_d  = '0;
    end
    if (wen && presc_hit && PRESC_EN) begin
      presc_d = (presc_q & ~wmask64[31:0]) | (wdata64[31:0] & wmask64[31:0]);
      pcnt_d  = '0;
    end

    for (int h = 0; h < NR_HARTS; h++) begin
      if (wen && cmp_hit && (cmp_idx == 13'(h))) begin
        mtimecmp_d[h] = (mtimecmp_q[h] & ~wmask64) | (wdata64 & wmask64);
      end
      if (wen && msip_hit && (bus.addr[13:3] == 11'(h / 2))) begin
        if (h % 2 == 0) begin
          if (wmask8[0]) msip_d[h] = wdata64[0];
        end else begin
          if (wmask8[4]) msip_d[h] = wdata64[32];
        end
      end
      tirq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end

    rvalid_d = bus.req;
    err_d    = bus.req && !hit;
    rdata_d  = ren ? rd_lane : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q  <= '0;
      pcnt_q   <= '0;
      presc_q  <= PRESC_INIT;
      for (int h = 0; h < NR_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
      msip_q   <= '0;
      tirq_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q    <= mtime_d;
      pcnt_q     <= pcnt_d;
      presc_q    <= presc_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      tirq_q     <= tirq_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.gnt     = bus.req;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign mtime_o     = mtime_q;
  assign timer_irq_o = tirq_q;
  assign ipi_o       = msip_q;

endmodule

// File: tb/tb_clint_mtimer.sv
// Directed bench for clint_mtimer with NR_HARTS=2, DATA_WIDTH=32.
module tb_clint_mtimer;
  localparam int NH = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          testmode;
  logic          halt;
  logic [63:0]   mtime;
  logic [NH-1:0] tirq;
  logic [NH-1:0] ipi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clint_mtimer_if #(.DATA_WIDTH(DW)) bus ();

  clint_mtimer #(
    .NR_HARTS(NH),
    .DATA_WIDTH(DW),
    .PRESCALE_RESET(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .testmode_i(testmode),
    .halt_i(halt),
    .bus(bus),
    .mtime_o(mtime),
    .timer_irq_o(tirq),
    .ipi_o(ipi)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_ipi;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
  endtask

  // Called at a negedge; drives one request and returns at the next negedge with req still high.
  task automatic access(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = be;
    #1;
    chk($sformatf("gnt @%h", a), 64'(bus.gnt), 64'd1);
    @(negedge clk);
    chk($sformatf("rvalid @%h", a), 64'(bus.rvalid), 64'd1);
    rd = bus.rdata;
    er = bus.err;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    access(1'b1, a, d, 4'hF, rd, er);
    chk($sformatf("wr err @%h", a), 64'(er), 64'd0);
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    access(1'b0, a, 32'h0, 4'h0, rd, er);
    chk($sformatf("rd data @%h", a), 64'(rd), 64'(exp));
    chk($sformatf("rd err @%h", a), 64'(er), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [63:0] exp_a;
    logic [63:0] exp_b;

    vt[0]  = '{1'b0, 16'h4000, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 2'b00};
    vt[1]  = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 2'b00};
    vt[2]  = '{1'b0, 16'h400C, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 2'b00};
    vt[3]  = '{1'b0, 16'h4010, 32'h0,        4'h0, 32'h0,         1'b1, 2'b00};
    vt[4]  = '{1'b1, 16'h0004, 32'h1,        4'hF, 32'h0,         1'b0, 2'b10};
    vt[5]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h1,         1'b0, 2'b10};
    vt[6]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,         1'b0, 2'b10};
    vt[7]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0, 2'b11};
    vt[8]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h1,         1'b0, 2'b11};
    vt[9]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0,         1'b1, 2'b11};
    vt[10] = '{1'b1, 16'h0008, 32'h1,        4'hF, 32'h0,         1'b1, 2'b11};
    vt[11] = '{1'b1, 16'h0004, 32'h0,        4'h0, 32'h0,         1'b0, 2'b11};
    vt[12] = '{1'b1, 16'h0004, 32'h0,        4'h1, 32'h0,         1'b0, 2'b01};
    vt[13] = '{1'b0, 16'hBFF4, 32'h0,        4'h0, 32'h0,         1'b0, 2'b01};
    vt[14] = '{1'b0, 16'h8000, 32'h0,        4'h0, 32'h0,         1'b1, 2'b01};
    vt[15] = '{1'b1, 16'h4008, 32'h1234_5678, 4'h3, 32'h0,        1'b0, 2'b01};
    vt[16] = '{1'b0, 16'h4008, 32'h0,        4'h0, 32'hFFFF_5678, 1'b0, 2'b01};
    vt[17] = '{1'b0, 16'h400C, 32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 2'b01};
    vt[18] = '{1'b1, 16'h0000, 32'h0,        4'hF, 32'h0,         1'b0, 2'b00};
    vt[19] = '{1'b0, 16'hBFF0, 32'h0,        4'h0, 32'h1,         1'b0, 2'b00};
    vt[20] = '{1'b0, 16'hC000, 32'h0,        4'h0, 32'h0,         1'b1, 2'b00};

    rst_n    = 1'b0;
    testmode = 1'b0;
    halt     = 1'b0;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("reset mtime", mtime, 64'd0);
    chk("reset tirq", 64'(tirq), 64'd0);
    chk("reset ipi", 64'(ipi), 64'd0);
    chk("reset rvalid", 64'(bus.rvalid), 64'd0);
    chk("reset rdata", 64'(bus.rdata), 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);

    // Default prescaler 1: one tick every two cycles.
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle10 mtime", mtime, 64'd5);
    chk("idle10 tirq", 64'(tirq), 64'd0);
    chk("idle10 ipi", 64'(ipi), 64'd0);

    for (int i = 0; i < 21; i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er);
      chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vt[i].exp_rdata));
      chk($sformatf("vec%0d err", i), 64'(er), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d ipi", i), 64'(ipi), 64'(vt[i].exp_ipi));
    end
    idle_bus();
    @(negedge clk);
    chk("rvalid drops", 64'(bus.rvalid), 64'd0);

    // Prescaler: mtime cleared first, then the prescaler write restarts pcnt.
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h0);
    wr(16'hBFF0, 32'h3);
    idle_bus();
`ifdef CLINT_MTIMER_PRESCALER_EN
    exp_a = 64'd0;
    exp_b = 64'd4;
`else
    exp_a = 64'd2;
    exp_b = 64'd8;
`endif
    repeat (3) @(negedge clk);
    chk("presc 3 cycles", mtime, exp_a);
    repeat (13) @(negedge clk);
    chk("presc 16 cycles", mtime, exp_b);
`ifdef CLINT_MTIMER_PRESCALER_EN
    rd_chk(16'hBFF0, 32'h3);
`else
    rd_chk(16'hBFF0, 32'h1);
`endif
    idle_bus();

    // Timer compare with testmode ticking every cycle.
    testmode = 1'b1;
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h0);
    wr(16'h4000, 32'h8);
    wr(16'h4004, 32'h0);
    idle_bus();
    for (int i = 0; i < 40; i++) begin
      if (mtime == 64'd8) break;
      @(negedge clk);
    end
    chk("reach mtime 8", mtime, 64'd8);
    chk("irq not yet", 64'(tirq[0]), 64'd0);
    @(negedge clk);
    chk("irq rises", 64'(tirq), 64'b01);
    wr(16'h4000, 32'd100);
    idle_bus();
    chk("irq held 1 after raise", 64'(tirq[0]), 64'd1);
    @(negedge clk);
    chk("irq falls", 64'(tirq[0]), 64'd0);

    // Wrap, and writes colliding with testmode ticks.
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    idle_bus();
    chk("collision write wins", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("pre wrap", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("wrap to 0", mtime, 64'd0);

    // Halt has priority over testmode.
    halt = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt frozen", mtime, 64'd0);
    rd_chk(16'hBFF8, 32'h0);
    rd_chk(16'hBFFC, 32'h0);
    idle_bus();
    halt = 1'b0;
    @(negedge clk);
    chk("resume tick", mtime, 64'd1);

    // Reset arriving together with a request drops the response.
    testmode = 1'b0;
    wr(16'h0000, 32'h1);
    chk("ipi before reset", 64'(ipi), 64'b01);
    bus.we   = 1'b0;
    bus.addr = 16'h4000;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("rst rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst rdata", 64'(bus.rdata), 64'd0);
    chk("rst ipi", 64'(ipi), 64'd0);
    chk("rst tirq", 64'(tirq), 64'd0);
    chk("rst mtime", mtime, 64'd0);
    rst_n = 1'b1;
    idle_bus();
    @(negedge clk);
    rd_chk(16'h4000, 32'hFFFF_FFFF);
    rd_chk(16'hBFF0, 32'h1);
    idle_bus();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
